// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and SDRAM-controller-side signals for sdram_arbiter.
// The arbiter connects through the slave modport; requesters and controller use master.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
);
    logic              init_done;
    logic [1:0]        req_read;
    logic [1:0]        req_write;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ack;
    logic [1:0]        req_err;
    logic [DATA_W-1:0] rdata;
    logic              rw_read;
    logic              rw_write;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_write;
    logic              rw_ack;
    logic [DATA_W-1:0] data_read;

    modport slave (
        input  init_done, req_read, req_write, req_addr0, req_addr1,
               req_wdata0, req_wdata1, rw_ack, data_read,
        output req_ack, req_err, rdata, rw_read, rw_write, data_addr, data_write
    );

    modport master (
        output init_done, req_read, req_write, req_addr0, req_addr1,
               req_wdata0, req_wdata1, rw_ack, data_read,
        input  req_ack, req_err, rdata, rw_read, rw_write, data_addr, data_write
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-requester round-robin arbiter in front of a single SDRAM controller port.
// Define ARB_TIMEOUT_EN to add an ISSUE-state watchdog that ends a stuck command with REQ_ERR.
module sdram_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    sdram_arbiter_if.slave     bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              grant, grant_n;
    logic              last, last_n;
    logic              op_write, op_write_n;
    logic              rw_read_q, rw_read_n;
    logic              rw_write_q, rw_write_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic [1:0]        ack_q, ack_n;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]   wd_q, wd_n;
    logic [1:0]        err_q, err_n;
`endif

    logic [1:0]        pending;
    logic              pick;
    logic              pick_write;

    // Round-robin choice: contention goes to the requester not served last.
    always_comb begin
        pending = bus.req_read | bus.req_write;
        if (pending == 2'b11) begin
            pick = ~last;
        end else begin
            pick = pending[1];
        end
        pick_write = pick ? bus.req_write[1] : bus.req_write[0];
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_n    = state;
        grant_n    = grant;
        last_n     = last;
        op_write_n = op_write;
        rw_read_n  = rw_read_q;
        rw_write_n = rw_write_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        rdata_n    = rdata_q;
        ack_n      = 2'b00;
`ifdef ARB_TIMEOUT_EN
        wd_n       = wd_q;
        err_n      = 2'b00;
`endif

        if (!bus.init_done) begin
            state_n    = WAIT_INIT;
            rw_read_n  = 1'b0;
            rw_write_n = 1'b0;
        end else begin
            unique case (state)
                WAIT_INIT: state_n = IDLE;

                IDLE: begin
                    if (|pending) begin
                        grant_n    = pick;
                        op_write_n = pick_write;
                        rw_write_n = pick_write;
                        rw_read_n  = ~pick_write;
                        addr_n     = pick ? bus.req_addr1  : bus.req_addr0;
                        wdata_n    = pick ? bus.req_wdata1 : bus.req_wdata0;
`ifdef ARB_TIMEOUT_EN
                        wd_n       = '0;
`endif
                        state_n    = ISSUE;
                    end
                end

                ISSUE: begin
                    if (bus.rw_ack) begin
                        rw_read_n  = 1'b0;
                        rw_write_n = 1'b0;
                        ack_n      = grant ? 2'b10 : 2'b01;
                        if (!op_write) begin
                            rdata_n = bus.data_read;
                        end
                        last_n     = grant;
                        state_n    = DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // This is the last allowed ISSUE cycle; give up on the controller.
                        rw_read_n  = 1'b0;
                        rw_write_n = 1'b0;
                        err_n      = grant ? 2'b10 : 2'b01;
                        last_n     = grant;
                        state_n    = DONE;
                    end else begin
                        wd_n = wd_q + WD_W'(1);
                    end
`endif
                end

                DONE: state_n = IDLE;

                default: state_n = WAIT_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_INIT;
            grant      <= 1'b0;
            last       <= 1'b1;
            op_write   <= 1'b0;
            rw_read_q  <= 1'b0;
            rw_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ack_q      <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 2'b00;
`endif
        end else begin
            // NOTE: non-blocking assignments make all registers update together from the previous cycle's values.
            state      <= state_n;
            grant      <= grant_n;
            last       <= last_n;
            op_write   <= op_write_n;
            rw_read_q  <= rw_read_n;
            rw_write_q <= rw_write_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            rdata_q    <= rdata_n;
            ack_q      <= ack_n;
`ifdef ARB_TIMEOUT_EN
            wd_q       <= wd_n;
            err_q      <= err_n;
`endif
        end
    end

    assign bus.rw_read    = rw_read_q;
    assign bus.rw_write   = rw_write_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_write = wdata_q;
    assign bus.rdata      = rdata_q;
    assign bus.req_ack    = ack_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.req_err    = err_q;
`else
    assign bus.req_err    = 2'b00;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard fed at stimulus time and drained on REQ_ACK/REQ_ERR.
module tb_sdram_arbiter;

    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 256;

    localparam int M_LAT    = 0;
    localparam int M_ALWAYS = 1;
    localparam int M_NEVER  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [1:0]        mask;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } sb_t;

    typedef struct {
        logic [1:0]        rd;
        logic [1:0]        wr;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] dread;
        int                lat;
        int                start;
        logic              grant;
        logic              write;
        logic              scr;
    } vec_t;

    sb_t               sb[$];
    int                n_cmp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] model_rdata = '0;

    int                ctrl_mode  = M_NEVER;
    int                ctrl_lat   = 1;
    logic [DATA_W-1:0] ctrl_rdata = '0;
    int                ctrl_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [1:0] rd, logic [1:0] wr,
                                logic [ADDR_W-1:0] a0, logic [ADDR_W-1:0] a1,
                                logic [DATA_W-1:0] d0, logic [DATA_W-1:0] d1,
                                logic [DATA_W-1:0] dread, int lat, int start,
                                logic grant, logic write, logic scr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.dread = dread; v.lat = lat; v.start = start;
        v.grant = grant; v.write = write; v.scr = scr;
        return v;
    endfunction

    // Controller model: acks after ctrl_lat command cycles, always, or never.
    initial begin
        logic ack;
        bus.rw_ack    = 1'b0;
        bus.data_read = '0;
        forever begin
            @(negedge clk);
            if (bus.rw_read || bus.rw_write) ctrl_cnt++;
            else ctrl_cnt = 0;
            case (ctrl_mode)
                M_LAT:    ack = (ctrl_cnt == ctrl_lat);
                M_ALWAYS: ack = 1'b1;
                default:  ack = 1'b0;
            endcase
            bus.rw_ack    = ack;
            bus.data_read = ack ? ctrl_rdata : ~ctrl_rdata;
        end
    end

    // Response monitor: every ACK/ERR pulse must match the oldest expectation.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (bus.req_ack !== 2'b00 || bus.req_err !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'({bus.req_err, bus.req_ack}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_ack", 64'(bus.req_ack), e.err ? 64'd0 : 64'(e.mask));
                    check("resp_err", 64'(bus.req_err), e.err ? 64'(e.mask) : 64'd0);
                    check("resp_rdata", 64'(bus.rdata), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        bus.req_read  = 2'b00;
        bus.req_write = 2'b00;
    endtask

    // Wait up to 8 cycles for a command; returns the cycle count at which it appeared.
    task automatic wait_cmd(output int cyc, output logic seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            tick();
            cyc++;
            seen = bus.rw_read | bus.rw_write;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int                cyc;
        int                hi;
        logic              seen;
        logic              got;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        sb_t               e;
        bus.req_addr0  = v.a0;
        bus.req_addr1  = v.a1;
        bus.req_wdata0 = v.d0;
        bus.req_wdata1 = v.d1;
        bus.req_read   = v.rd;
        bus.req_write  = v.wr;
        ctrl_mode      = M_LAT;
        ctrl_lat       = v.lat;
        ctrl_rdata     = v.dread;
        ea = v.grant ? v.a1 : v.a0;
        ed = v.grant ? v.d1 : v.d0;
        if (!v.write) model_rdata = v.dread;
        e.mask  = v.grant ? 2'b10 : 2'b01;
        e.err   = 1'b0;
        e.rdata = model_rdata;
        sb.push_back(e);

        wait_cmd(cyc, seen);
        check({tag, "_start"}, 64'(cyc), 64'(v.start));
        check({tag, "_op"}, 64'({bus.rw_write, bus.rw_read}), v.write ? 64'd2 : 64'd1);
        check({tag, "_addr"}, 64'(bus.data_addr), 64'(ea));
        if (v.write) check({tag, "_wdata"}, 64'(bus.data_write), 64'(ed));

        if (v.scr) begin
            bus.req_addr0  = ADDR_W'($urandom);
            bus.req_addr1  = ADDR_W'($urandom);
            bus.req_wdata0 = $urandom;
            bus.req_wdata1 = $urandom;
            bus.req_read   = ~v.rd;
            bus.req_write  = ~v.wr;
        end

        hi  = 1;
        got = 1'b0;
        while (!got && hi < 40) begin
            tick();
            if (bus.req_ack != 2'b00) begin
                got = 1'b1;
            end else begin
                check({tag, "_hold"}, 64'({bus.rw_write, bus.rw_read, bus.data_addr}),
                      64'({v.write, ~v.write, ea}));
                hi++;
            end
        end
        check({tag, "_ack_seen"}, 64'(got), 64'd1);
        check({tag, "_cmd_cycles"}, 64'(hi), 64'(v.lat));
        check({tag, "_cmd_low"}, 64'({bus.rw_write, bus.rw_read}), 64'd0);
        drop_reqs();
        tick();
        check({tag, "_ack_pulse"}, 64'(bus.req_ack), 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int   cyc;
        int   n;
        logic seen;
        logic any_cmd;
        sb_t  e;

        vecs[0] = mk(2'b00, 2'b01, 25'h0000010, 25'h0AAAAAA, 32'h12345678, 32'h0,        32'hBAADBEEF, 3, 1, 1'b0, 1'b1, 1'b0);
        vecs[1] = mk(2'b10, 2'b00, 25'h0000001, 25'h1FFFFFF, 32'h0,        32'h0,        32'hFABBDAAD, 1, 1, 1'b1, 1'b0, 1'b0);
        vecs[2] = mk(2'b00, 2'b01, 25'h0000000, 25'h1234567, 32'hFFFFFFFF, 32'h0,        32'hBAADBEEF, 2, 1, 1'b0, 1'b1, 1'b0);
        vecs[3] = mk(2'b11, 2'b00, 25'h0000100, 25'h0000200, 32'h0,        32'h0,        32'h13579BDF, 1, 1, 1'b1, 1'b0, 1'b0);
        vecs[4] = mk(2'b01, 2'b10, 25'h0000300, 25'h0000400, 32'h11111111, 32'h22222222, 32'h2468ACE0, 2, 1, 1'b0, 1'b0, 1'b0);
        vecs[5] = mk(2'b00, 2'b11, 25'h0000500, 25'h0000600, 32'h33333333, 32'h44444444, 32'hBAADBEEF, 1, 1, 1'b1, 1'b1, 1'b0);
        vecs[6] = mk(2'b10, 2'b10, 25'h0000700, 25'h1555555, 32'h55555555, 32'h66666666, 32'hBAADBEEF, 2, 1, 1'b1, 1'b1, 1'b0);
        vecs[7] = mk(2'b01, 2'b01, 25'h0ABCDEF, 25'h0000800, 32'h77777777, 32'h88888888, 32'hBAADBEEF, 4, 1, 1'b0, 1'b1, 1'b1);
        vecs[8] = mk(2'b10, 2'b00, 25'h0000900, 25'h1000000, 32'h0,        32'h0,        32'h0F0F0F0F, 5, 1, 1'b1, 1'b0, 1'b1);

        bus.init_done  = 1'b0;
        bus.req_read   = 2'b01;
        bus.req_write  = 2'b00;
        bus.req_addr0  = 25'h0000123;
        bus.req_addr1  = 25'h0000456;
        bus.req_wdata0 = '0;
        bus.req_wdata1 = '0;

        // Reset values
        repeat (2) tick();
        check("rst_rw_read",    64'(bus.rw_read),    64'd0);
        check("rst_rw_write",   64'(bus.rw_write),   64'd0);
        check("rst_data_addr",  64'(bus.data_addr),  64'd0);
        check("rst_data_write", 64'(bus.data_write), 64'd0);
        check("rst_rdata",      64'(bus.rdata),      64'd0);
        check("rst_req_ack",    64'(bus.req_ack),    64'd0);
        check("rst_req_err",    64'(bus.req_err),    64'd0);
        rst = 1'b0;

        // No command may issue while initialisation is pending
        any_cmd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_cmd = any_cmd | bus.rw_read | bus.rw_write;
        end
        check("preinit_cmd", 64'(any_cmd), 64'd0);
        bus.init_done = 1'b1;
        run_vec(mk(2'b01, 2'b00, 25'h0000123, 25'h0000456, 32'h0, 32'h0, 32'h0BADF00D, 2, 2, 1'b0, 1'b0, 1'b0), "init");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Continuous contention with RW_ACK stuck high: grants alternate 0,1,0,1
        ctrl_mode   = M_ALWAYS;
        ctrl_rdata  = 32'hC0DECAFE;
        model_rdata = 32'hC0DECAFE;
        for (int k = 0; k < 4; k++) begin
            e.mask  = (k % 2 == 1) ? 2'b10 : 2'b01;
            e.err   = 1'b0;
            e.rdata = model_rdata;
            sb.push_back(e);
        end
        bus.req_read = 2'b11;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.req_ack != 2'b00) n++;
        end
        drop_reqs();
        check("rr_acks", 64'(n), 64'd4);
        check("rr_cycles", 64'(cyc), 64'd11);
        tick();
        ctrl_mode = M_LAT;

        // INIT_DONE falling mid-ISSUE abandons the command
        ctrl_mode     = M_NEVER;
        bus.req_write = 2'b01;
        bus.req_addr0 = 25'h0000AAA;
        wait_cmd(cyc, seen);
        check("idrop_cmd_seen", 64'(seen), 64'd1);
        tick();
        bus.init_done = 1'b0;
        tick();
        check("idrop_cmd_low", 64'({bus.rw_write, bus.rw_read}), 64'd0);
        drop_reqs();
        repeat (2) tick();
        check("idrop_still_low", 64'({bus.rw_write, bus.rw_read}), 64'd0);
        bus.init_done = 1'b1;
        tick();
        run_vec(mk(2'b00, 2'b01, 25'h0000B00, 25'h0000C00, 32'h9ABCDEF0, 32'h0, 32'hBAADBEEF, 2, 1, 1'b0, 1'b1, 1'b0), "post_idrop");

        // Reset mid-ISSUE: commands drop at once, no response, pointer restored
        ctrl_mode    = M_NEVER;
        bus.req_read = 2'b10;
        wait_cmd(cyc, seen);
        check("rstmid_cmd_seen", 64'(bus.rw_read), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_cmd_async", 64'({bus.rw_write, bus.rw_read}), 64'd0);
        drop_reqs();
        model_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        run_vec(mk(2'b00, 2'b11, 25'h0000D00, 25'h0000E00, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hBAADBEEF, 2, 2, 1'b0, 1'b1, 1'b0), "post_rst");

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no RW_ACK ever, REQ_ERR after TIMEOUT ISSUE cycles
        ctrl_mode    = M_NEVER;
        bus.req_read = 2'b01;
        e.mask  = 2'b01;
        e.err   = 1'b1;
        e.rdata = model_rdata;
        sb.push_back(e);
        wait_cmd(cyc, seen);
        check("wd_cmd_seen", 64'(seen), 64'd1);
        n = 1;
        seen = 1'b0;
        while (!seen && n < TIMEOUT + 20) begin
            tick();
            if (bus.req_err != 2'b00) seen = 1'b1;
            else n++;
        end
        check("wd_err_seen", 64'(seen), 64'd1);
        check("wd_cycles", 64'(n), 64'(TIMEOUT));
        check("wd_no_ack", 64'(bus.req_ack), 64'd0);
        check("wd_cmd_low", 64'({bus.rw_write, bus.rw_read}), 64'd0);
        drop_reqs();
        tick();
        run_vec(mk(2'b10, 2'b00, 25'h0000F00, 25'h0001000, 32'h0, 32'h0, 32'h76543210, 2, 1, 1'b1, 1'b0, 1'b0), "post_wd");
`endif

        repeat (3) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, SDRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SDRAM data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, watchdog limit; used only when ARB_TIMEOUT_EN is defined.
REQ-004 Clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 INIT_DONE  in  1  SDRAM controller initialisation complete.
REQ-007 REQ_READ  in  2  per-requester read request; bit n belongs to requester n.
REQ-008 REQ_WRITE  in  2  per-requester write request.
REQ-009 REQ_ADDR0, REQ_ADDR1  in  ADDR_W each  requester addresses.
REQ-010 REQ_WDATA0, REQ_WDATA1  in  DATA_W each  requester write data.
REQ-011 REQ_ACK  out  2  one-cycle completion pulse to the served requester.
REQ-012 REQ_ERR  out  2  one-cycle timeout pulse to the served requester.
REQ-013 RDATA  out  DATA_W  registered read data; shared by both requesters.
REQ-014 RW_READ, RW_WRITE  out  1 each  SDRAM controller commands.
REQ-015 DATA_ADDR  out  ADDR_W; DATA_WRITE  out  DATA_W  command address and write data.
REQ-016 RW_ACK  in  1  controller completion strobe; DATA_READ  in  DATA_W  valid while RW_ACK is high.

Function
REQ-017 FSM states: WAIT_INIT, IDLE, ISSUE, DONE.
REQ-018 WAIT_INIT -> IDLE on the first cycle INIT_DONE=1; no request is accepted before that.
REQ-019 A requester is pending when its REQ_READ or REQ_WRITE bit is high.
REQ-020 In IDLE with any pending request: grant by round-robin and go to ISSUE.
REQ-021 Round-robin rule: when both requesters are pending, grant the one not served last; after reset, requester 0 wins first.
REQ-022 Latch grant index, op, address and write data on grant; DATA_ADDR, DATA_WRITE and RW_READ/RW_WRITE are registered and assert the cycle after the grant decision.
REQ-023 If REQ_READ and REQ_WRITE are both high for one requester, write wins.
REQ-024 ISSUE: hold RW_READ or RW_WRITE, DATA_ADDR and DATA_WRITE stable until RW_ACK=1.
REQ-025 When RW_ACK=1 in ISSUE:
- next cycle: RW_READ and RW_WRITE low; REQ_ACK[grant] high for exactly one cycle.
- for a read, RDATA captures DATA_READ, valid coincident with REQ_ACK.
- FSM goes to DONE.
REQ-026 DONE lasts one cycle, ignores requests, then returns to IDLE; requesters drop their request on REQ_ACK, so no transaction is served twice.
REQ-027 RDATA holds its value until the next read completes; writes leave it unchanged.
REQ-028 RW_ACK in IDLE, DONE or WAIT_INIT is ignored.
REQ-029 Request changes during ISSUE do not alter latched address, data or op.
REQ-030 INIT_DONE falling in any state returns the FSM to WAIT_INIT next cycle, with commands low and no ACK.

Reset
REQ-031 Reset asserted forces WAIT_INIT immediately, independent of Clk.
REQ-032 Reset values: RW_READ=0, RW_WRITE=0, DATA_ADDR=0, DATA_WRITE=0, RDATA=0, REQ_ACK=0, REQ_ERR=0, round-robin pointer = requester 1 last served, watchdog=0.
REQ-033 Reset mid-transaction abandons it silently; no ACK or ERR is issued.

Configuration
REQ-034 Macro ARB_TIMEOUT_EN defined adds a watchdog counting ISSUE cycles; it is cleared on entry to ISSUE.
REQ-035 When the count reaches TIMEOUT_CYCLES without RW_ACK: next cycle commands go low, REQ_ERR[grant] pulses for one cycle, no REQ_ACK, RDATA unchanged, FSM goes to DONE.
REQ-036 Without ARB_TIMEOUT_EN, ISSUE waits indefinitely, REQ_ERR is tied 0 and no counter logic exists.

Verification
REQ-037 Reset, INIT_DONE=0, REQ_READ=2'b01 for 20 cycles -> RW_READ stays 0; set INIT_DONE=1 -> RW_READ=1 with DATA_ADDR=REQ_ADDR0 within 2 cycles.
REQ-038 Requester 0 write, addr 25'h000010, data 32'h12345678; RW_ACK after 3 cycles -> RW_WRITE high 3 cycles, DATA_WRITE=32'h12345678, REQ_ACK=2'b01 for one cycle.
REQ-039 Both requesters request reads continuously, RW_ACK=1 always -> grants alternate 0,1,0,1; each REQ_ACK bit pulses every other transaction.
REQ-040 Requester 1 read with DATA_READ=32'hFABBDAAD at RW_ACK -> RDATA=32'hFABBDAAD coincident with REQ_ACK=2'b10, held through a following write.
REQ-041 Reset pulsed mid-ISSUE -> RW_READ and RW_WRITE go 0 immediately and no REQ_ACK is seen; after reset requester 0 wins a simultaneous request.
REQ-042 With ARB_TIMEOUT_EN and RW_ACK held 0 -> REQ_ERR pulses after 256 ISSUE cycles, the FSM returns to IDLE, and the next request is served normally.
